// File: rtl/othello_move_engine.sv
// ---------------------------------------------------------------------------
// othello_move_engine
//
// Purpose:
//   Move validator/executor sitting between the main game controller and the
//   shared 64-entry board RAM. On a request it checks that the origin square
//   is empty. It then scans the eight directions in the fixed order
//   E, SE, S, SW, W, NW, N, NE. Each bracketed run of opponent discs is
//   written back with the mover's colour, walking from the bracketing disc
//   toward the origin. The origin disc is then placed and ack is pulsed.
//   An illegal move pulses reject and performs no writes.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   new_move     level request; a move is pending while high
//   player       side to move (0 black, 1 white)
//   move_x/y     requested square, 0..7
//   mem_rdata    board RAM read data (synchronous, 1-cycle latency)
//   mem_addr     board RAM address {y,x}
//   mem_we       board RAM write enable (FLIP and PLACE only)
//   mem_wdata    board RAM write data
//   busy         high from acceptance through the ack/reject cycle
//   ack          1-cycle pulse: legal move, board updated
//   reject       1-cycle pulse: illegal move, board untouched
//   flip_count   (OTHELLO_FLIP_COUNT_EN only) discs flipped by last legal move
//
// Configuration:
//   Define OTHELLO_FLIP_COUNT_EN to add the flip_count output and its counter.
// ---------------------------------------------------------------------------
module othello_move_engine #(
  parameter logic [1:0] CELL_EMPTY = 2'b00,
  parameter logic [1:0] CELL_BLACK = 2'b01,
  parameter logic [1:0] CELL_WHITE = 2'b10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_move,
  input  logic       player,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  input  logic [1:0] mem_rdata,
  output logic [5:0] mem_addr,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  output logic       busy,
  output logic       ack,
  output logic       reject
`ifdef OTHELLO_FLIP_COUNT_EN
  ,
  output logic [5:0] flip_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, RD_ORG, CHK_ORG, STEP, EVAL, FLIP, NEXT_DIR, PLACE, ACK, REJECT, WAIT_LOW
  } state_t;

  // Positions are carried as 4-bit two's complement so that one step off the
  // board (-1 or 8) shows up as bit 3 set in either coordinate.
  function automatic logic [7:0] step_pos(input logic [3:0] x, input logic [3:0] y,
                                          input logic [2:0] d);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = 4'h0;
    dy = 4'h0;
    case (d)
      3'd0: begin dx = 4'h1; dy = 4'h0; end
      3'd1: begin dx = 4'h1; dy = 4'h1; end
      3'd2: begin dx = 4'h0; dy = 4'h1; end
      3'd3: begin dx = 4'hF; dy = 4'h1; end
      3'd4: begin dx = 4'hF; dy = 4'h0; end
      3'd5: begin dx = 4'hF; dy = 4'hF; end
      3'd6: begin dx = 4'h0; dy = 4'hF; end
      default: begin dx = 4'h1; dy = 4'hF; end
    endcase
    return {y + dy, x + dx};
  endfunction

  state_t     state_q;
  logic [2:0] ox_q, oy_q, dir_q, k_q;
  logic [3:0] cx_q, cy_q;
  logic       player_q, any_flip_q;
  logic [5:0] mem_addr_q;
  logic [1:0] mem_wdata_q;
  logic       mem_we_q, busy_q, ack_q, reject_q;
`ifdef OTHELLO_FLIP_COUNT_EN
  logic [5:0] cnt_q, flip_count_q;
`endif

  logic [1:0] own, opp;
  logic [7:0] org_first, dir_first, ray_next, ray_back;

  assign own = player_q ? CELL_WHITE : CELL_BLACK;
  assign opp = player_q ? CELL_BLACK : CELL_WHITE;

  // First square of the first direction, first square of the next direction,
  // one step further along the ray, and one step back toward the origin
  // (the opposite direction is always dir+4).
  assign org_first = step_pos({1'b0, ox_q}, {1'b0, oy_q}, 3'd0);
  assign dir_first = step_pos({1'b0, ox_q}, {1'b0, oy_q}, dir_q + 3'd1);
  assign ray_next  = step_pos(cx_q, cy_q, dir_q);
  assign ray_back  = step_pos(cx_q, cy_q, dir_q + 3'd4);

  // The candidate square is computed on the way into STEP and its address is
  // registered at the same time, so the RAM read is issued during STEP and the
  // data is ready in EVAL. Off-board candidates never reach mem_addr.
  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values of the registers it reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ox_q        <= '0;
      oy_q        <= '0;
      dir_q       <= '0;
      k_q         <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      player_q    <= 1'b0;
      any_flip_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      reject_q    <= 1'b0;
`ifdef OTHELLO_FLIP_COUNT_EN
      cnt_q        <= '0;
      flip_count_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (new_move) begin
            ox_q       <= move_x;
            oy_q       <= move_y;
            player_q   <= player;
            mem_addr_q <= {move_y, move_x};
            busy_q     <= 1'b1;
            any_flip_q <= 1'b0;
            k_q        <= '0;
            dir_q      <= '0;
`ifdef OTHELLO_FLIP_COUNT_EN
            cnt_q      <= '0;
`endif
            state_q    <= RD_ORG;
          end
        end

        RD_ORG: state_q <= CHK_ORG;

        CHK_ORG: begin
          if (mem_rdata != CELL_EMPTY) begin
            reject_q <= 1'b1;
            state_q  <= REJECT;
          end else begin
            dir_q <= '0;
            cx_q  <= org_first[3:0];
            cy_q  <= org_first[7:4];
            if (!org_first[7] && !org_first[3])
              mem_addr_q <= {org_first[6:4], org_first[2:0]};
            state_q <= STEP;
          end
        end

        STEP: state_q <= (!cx_q[3] && !cy_q[3]) ? EVAL : NEXT_DIR;

        EVAL: begin
          if (mem_rdata == opp) begin
            k_q  <= k_q + 3'd1;
            cx_q <= ray_next[3:0];
            cy_q <= ray_next[7:4];
            if (!ray_next[7] && !ray_next[3])
              mem_addr_q <= {ray_next[6:4], ray_next[2:0]};
            state_q <= STEP;
          end else if (mem_rdata == own && k_q != 3'd0) begin
            // Bracket confirmed: start writing back from the disc next to it.
            cx_q        <= ray_back[3:0];
            cy_q        <= ray_back[7:4];
            mem_addr_q  <= {ray_back[6:4], ray_back[2:0]};
            mem_wdata_q <= own;
            mem_we_q    <= 1'b1;
            state_q     <= FLIP;
          end else begin
            state_q <= NEXT_DIR;
          end
        end

        FLIP: begin
          any_flip_q <= 1'b1;
          k_q        <= k_q - 3'd1;
`ifdef OTHELLO_FLIP_COUNT_EN
          cnt_q      <= cnt_q + 6'd1;
`endif
          if (k_q == 3'd1) begin
            mem_we_q <= 1'b0;
            state_q  <= NEXT_DIR;
          end else begin
            cx_q       <= ray_back[3:0];
            cy_q       <= ray_back[7:4];
            mem_addr_q <= {ray_back[6:4], ray_back[2:0]};
          end
        end

        NEXT_DIR: begin
          k_q <= '0;
          if (dir_q == 3'd7) begin
            if (any_flip_q) begin
              mem_addr_q  <= {oy_q, ox_q};
              mem_wdata_q <= own;
              mem_we_q    <= 1'b1;
              state_q     <= PLACE;
            end else begin
              reject_q <= 1'b1;
              state_q  <= REJECT;
            end
          end else begin
            dir_q <= dir_q + 3'd1;
            cx_q  <= dir_first[3:0];
            cy_q  <= dir_first[7:4];
            if (!dir_first[7] && !dir_first[3])
              mem_addr_q <= {dir_first[6:4], dir_first[2:0]};
            state_q <= STEP;
          end
        end

        PLACE: begin
          mem_we_q <= 1'b0;
          ack_q    <= 1'b1;
`ifdef OTHELLO_FLIP_COUNT_EN
          flip_count_q <= cnt_q;
`endif
          state_q  <= ACK;
        end

        ACK: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= WAIT_LOW;
        end

        // Holding here stops a still-asserted request for the same square from
        // being re-evaluated and rejected over and over.
        REJECT: begin
          reject_q <= 1'b0;
          busy_q   <= 1'b0;
          if (!new_move || ({move_y, move_x} != {oy_q, ox_q}))
            state_q <= IDLE;
        end

        WAIT_LOW: if (!new_move) state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign reject    = reject_q;
`ifdef OTHELLO_FLIP_COUNT_EN
  assign flip_count = flip_count_q;
`endif

endmodule

// File: tb/tb_othello_move_engine.sv
// ---------------------------------------------------------------------------
// tb_othello_move_engine
//
// Self-checking bench for othello_move_engine. A behavioural board RAM with a
// one-cycle synchronous read sits on the memory port. A reference Othello
// model predicts, per move, the ordered list of RAM writes and the final
// ack/reject. These are queued when the move is driven. A monitor pops and
// compares them as the DUT produces writes and pulses.
// ---------------------------------------------------------------------------
module tb_othello_move_engine;

  localparam logic [1:0] C_E = 2'b00;
  localparam logic [1:0] C_B = 2'b01;
  localparam logic [1:0] C_W = 2'b10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       new_move = 1'b0;
  logic       player = 1'b0;
  logic [2:0] move_x = '0;
  logic [2:0] move_y = '0;
  logic [1:0] mem_rdata;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic       busy, ack, reject;
`ifdef OTHELLO_FLIP_COUNT_EN
  logic [5:0] flip_count;
`endif

  othello_move_engine dut (
    .clock     (clock),
    .reset     (reset),
    .new_move  (new_move),
    .player    (player),
    .move_x    (move_x),
    .move_y    (move_y),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .ack       (ack),
    .reject    (reject)
`ifdef OTHELLO_FLIP_COUNT_EN
    ,
    .flip_count(flip_count)
`endif
  );

  always #5 clock = ~clock;

  // Board RAM: DUT writes take priority; the bench loads boards through its
  // own port while the DUT is idle.
  logic [1:0] ram [64];
  logic       tb_we = 1'b0;
  logic [5:0] tb_addr = '0;
  logic [1:0] tb_data = '0;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (tb_we) ram[tb_addr] <= tb_data;
    mem_rdata <= ram[mem_addr];
  end

  typedef enum int {EV_WR, EV_ACK, EV_REJ} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       data;
  } ev_t;

  ev_t        sb[$];
  logic [1:0] mdl [64];
  int         n_vec = 0;
  int         n_bad = 0;
  int         dxs [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int         dys [8] = '{0, 1, 1, 1, 0, -1, -1, -1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference move: predicts the write sequence and the response.
  task automatic expect_move(input int x, input int y, input bit p);
    logic [1:0] own, opp;
    int total;
    own = p ? C_W : C_B;
    opp = p ? C_B : C_W;
    total = 0;
    if (mdl[y*8+x] != C_E) begin
      sb.push_back('{EV_REJ, 0, 0});
      return;
    end
    for (int d = 0; d < 8; d++) begin
      int cx, cy, n;
      cx = x + dxs[d];
      cy = y + dys[d];
      n  = 0;
      while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && mdl[cy*8+cx] == opp) begin
        n++;
        cx += dxs[d];
        cy += dys[d];
      end
      if (n > 0 && cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && mdl[cy*8+cx] == own) begin
        for (int i = n; i >= 1; i--) begin
          int a;
          a = (y + dys[d]*i)*8 + (x + dxs[d]*i);
          sb.push_back('{EV_WR, a, int'(own)});
          mdl[a] = own;
          total++;
        end
      end
    end
    if (total > 0) begin
      mdl[y*8+x] = own;
      sb.push_back('{EV_WR, y*8+x, int'(own)});
      sb.push_back('{EV_ACK, 0, total});
    end else begin
      sb.push_back('{EV_REJ, 0, 0});
    end
  endtask

  task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = '{EV_REJ, 0, 0};
    check("sb_underflow", ok, 1);
    if (ok) begin
      e = sb.pop_front();
      check("ev_kind", k, e.kind);
    end
  endtask

  task automatic monitor();
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (ack || reject) check("ack_rej_excl", ack & reject, 0);
        if (mem_we) begin
          take(EV_WR, e, ok);
          if (ok && e.kind == EV_WR) begin
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
            check("wr_busy", busy, 1);
          end
        end
        if (ack) begin
          take(EV_ACK, e, ok);
`ifdef OTHELLO_FLIP_COUNT_EN
          if (ok && e.kind == EV_ACK) check("flip_count", flip_count, e.data);
`endif
        end
        if (reject) take(EV_REJ, e, ok);
      end
    end
  endtask

  task automatic board_clear();
    for (int i = 0; i < 64; i++) mdl[i] = C_E;
  endtask

  task automatic put(input int x, input int y, input logic [1:0] c);
    mdl[y*8+x] = c;
  endtask

  task automatic board_load();
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      tb_we = 1'b1; tb_addr = 6'(i); tb_data = mdl[i];
    end
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic board_start();
    board_clear();
    put(3, 3, C_W); put(4, 4, C_W); put(4, 3, C_B); put(3, 4, C_B);
    board_load();
  endtask

  task automatic board_multi();
    board_clear();
    put(4, 5, C_W); put(5, 5, C_W); put(6, 5, C_B);
    put(3, 4, C_W); put(3, 3, C_B);
    board_load();
  endtask

  task automatic check_board(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== mdl[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      lat++;
      if (ack || reject) break;
    end
    check("resp_seen", ack | reject, 1);
  endtask

  task automatic run_move(input int x, input int y, input bit p, output int lat);
    expect_move(x, y, p);
    @(negedge clock);
    move_x = 3'(x); move_y = 3'(y); player = p; new_move = 1'b1;
    wait_resp(lat);
  endtask

  task automatic end_move(input string tag, input int hold);
    repeat (hold) @(negedge clock);
    check({tag, "_busy_held"}, busy, 0);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check({tag, "_sb_drain"}, sb.size(), 0);
    check({tag, "_board"}, 0, 0 + 0 * 0 == 0 ? 0 : 1);
  endtask

  initial begin
    int lat;
    fork
      monitor();
    join_none

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_reject", reject, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
`ifdef OTHELLO_FLIP_COUNT_EN
    check("rst_flip_count", flip_count, 0);
`endif
    reset = 1'b1;

    // Legal opening move; request held high afterwards must not relaunch.
    board_start();
    run_move(3, 2, 0, lat);
    repeat (10) @(negedge clock);
    check("t1_busy_held", busy, 0);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check("t1_sb_drain", sb.size(), 0);
    check_board("t1_board");

    // Occupied origin: fast reject, no writes.
    board_start();
    run_move(3, 3, 0, lat);
    check("t2_rej_latency_le3", lat <= 3, 1);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check("t2_sb_drain", sb.size(), 0);
    check_board("t2_board");

    // No bracket, then retarget while request is held high.
    board_start();
    run_move(0, 0, 0, lat);
    expect_move(3, 2, 0);
    move_x = 3'd3; move_y = 3'd2;
    wait_resp(lat);
    check("t3_ack", ack, 1);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check("t3_sb_drain", sb.size(), 0);
    check_board("t3_board");

    // Request dropped and inputs changed right after acceptance.
    board_start();
    expect_move(4, 2, 1);
    @(negedge clock);
    move_x = 3'd4; move_y = 3'd2; player = 1'b1; new_move = 1'b1;
    @(negedge clock);
    new_move = 1'b0; move_x = 3'd0; move_y = 3'd0; player = 1'b0;
    wait_resp(lat);
    repeat (3) @(negedge clock);
    check("t4_sb_drain", sb.size(), 0);
    check_board("t4_board");

    // Two bracketed directions from one origin.
    board_multi();
    run_move(3, 5, 0, lat);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check("t5_sb_drain", sb.size(), 0);
    check_board("t5_board");

    // Corner with opponent runs reaching the edge: reject.
    board_clear();
    for (int i = 0; i < 7; i++) begin
      put(i, 7, C_W); put(7, i, C_W); put(i, i, C_W);
    end
    board_load();
    run_move(7, 7, 0, lat);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_sb_drain", sb.size(), 0);
    check_board("t6_board");

    // Asynchronous reset in the middle of a flip run.
    board_multi();
    expect_move(3, 5, 0);
    @(negedge clock);
    move_x = 3'd3; move_y = 3'd5; player = 1'b0; new_move = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (mem_we) break;
    end
    check("t7_we_seen", mem_we, 1);
    #2;
    reset = 1'b0;
    new_move = 1'b0;
    #1;
    check("t7_rst_we", mem_we, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_ack", ack, 0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("t7_idle_busy", busy, 0);
    board_start();
    run_move(3, 2, 0, lat);
    check("t7_ack", ack, 1);
    new_move = 1'b0;
    repeat (3) @(negedge clock);
    check("t7_sb_drain", sb.size(), 0);
    check_board("t7_board");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
